// File: rtl/kernel_conv.sv
// Normalised 2-D convolution of one pixel window: a serial multiply-accumulate over the
// active N x N taps, followed by a restoring divide by the kernel sum and saturation to 8 bits.
module kernel_conv #(
  parameter int MAX_KERNEL = 7
) (
  input  logic                                           clk,
  input  logic                                           n_rst,
  input  logic [$clog2(MAX_KERNEL)-1:0]                  kernel_size,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]     kernel,
  input  logic [31:0]                                    kernel_sum,
  input  logic                                           kernel_load,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]     window,
  input  logic                                           win_valid,
  output logic                                           win_ready,
  output logic [7:0]                                     pixel_out,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           div_err,
  output logic                                           busy,
  output logic [1:0]                                     dbg_state
);

  localparam int NW = $clog2(MAX_KERNEL);
  localparam logic [NW-1:0] ONE_N = 1;

  // Handshakes: a window transfers on a rising edge with win_valid && win_ready;
  // a result transfers on a rising edge with out_valid && out_ready. Neither valid
  // depends combinationally on the opposite ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DIV  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                                       r_state;
  logic                                         r_pending;
  logic                                         r_kernel_ok;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   r_w;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   r_win;
  logic [31:0]                                  r_sum;
  logic [NW-1:0]                                r_n;
  logic [NW-1:0]                                r_x;
  logic [NW-1:0]                                r_y;
  logic [31:0]                                  r_acc;
  logic [31:0]                                  r_quo;
  logic [31:0]                                  r_rem;
  logic [4:0]                                   r_cnt;
  logic [7:0]                                   r_pixel;
  logic                                         r_div_err;

  logic [NW-1:0]  w_nm1;
  logic [7:0]     w_pix;
  logic [7:0]     w_wt;
  logic [15:0]    w_prod;
  logic [31:0]    w_acc_nx;
  logic [32:0]    w_rem_sh;
  logic           w_ge;
  logic [31:0]    w_diff;
  logic [31:0]    w_quo_nx;
  logic [7:0]     w_sat;
  logic           w_win_ready;

  assign w_nm1    = r_n - ONE_N;
  assign w_pix    = r_win[r_x][r_y];
  assign w_wt     = r_w[r_x][r_y];
  assign w_prod   = {8'd0, w_pix} * {8'd0, w_wt};
  assign w_acc_nx = r_acc + {16'd0, w_prod};

  // One restoring step; the remainder stays below the divisor, so the low 32 bits of the
  // difference are exact whenever the subtraction is taken.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_sum});
  assign w_diff   = w_rem_sh[31:0] - r_sum;
  assign w_quo_nx = {r_quo[30:0], w_ge};
  assign w_sat    = (w_quo_nx[31:8] != 24'd0) ? 8'hFF : w_quo_nx[7:0];

  assign w_win_ready = (r_state == S_IDLE) && r_kernel_ok && !r_pending;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_kernel_ok <= 1'b0;
      r_w         <= '0;
      r_win       <= '0;
      r_sum       <= '0;
      r_n         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_pixel     <= '0;
      r_div_err   <= 1'b0;
    end else begin
      if (kernel_load) begin
        r_pending <= 1'b1;
      end else if ((r_state == S_IDLE) && r_pending) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // A pending kernel capture always wins over accepting a window.
          if (r_pending) begin
            r_w         <= kernel;
            r_sum       <= kernel_sum;
            r_n         <= (kernel_size == '0) ? ONE_N : kernel_size;
            r_kernel_ok <= 1'b1;
          end else if (win_valid && w_win_ready) begin
            r_win   <= window;
            r_acc   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_nx;
          if (r_x == w_nm1) begin
            r_x <= '0;
            if (r_y == w_nm1) begin
              r_quo   <= w_acc_nx;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end else begin
              r_y <= r_y + ONE_N;
            end
          end else begin
            r_x <= r_x + ONE_N;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_rem_sh[31:0];
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_pixel   <= (r_sum == 32'd0) ? 8'd0 : w_sat;
            r_div_err <= (r_sum == 32'd0);
            r_state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_div_err <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign win_ready = w_win_ready;
  assign pixel_out = r_pixel;
  assign out_valid = (r_state == S_OUT);
  assign div_err   = r_div_err;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_kernel_conv.sv
// Directed bench for kernel_conv: a table of uniform-kernel vectors plus hand-written
// sequences for index asymmetry, late kernel loads, output back-pressure and reset.
module tb_kernel_conv;

  localparam int MK = 7;
  localparam int NW = $clog2(MK);

  logic                             clk = 1'b0;
  logic                             n_rst;
  logic [NW-1:0]                    kernel_size;
  logic [MK-1:0][MK-1:0][7:0]       kernel;
  logic [31:0]                      kernel_sum;
  logic                             kernel_load;
  logic [MK-1:0][MK-1:0][7:0]       window;
  logic                             win_valid;
  logic                             win_ready;
  logic [7:0]                       pixel_out;
  logic                             out_valid;
  logic                             out_ready;
  logic                             div_err;
  logic                             busy;
  logic [1:0]                       dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    int w;
    int sum;
    int pa;
    int pi;
    int exp_pix;
    int exp_err;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  kernel_conv #(.MAX_KERNEL(MK)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .kernel_size (kernel_size),
    .kernel      (kernel),
    .kernel_sum  (kernel_sum),
    .kernel_load (kernel_load),
    .window      (window),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .pixel_out   (pixel_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .div_err     (div_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Active taps get weight w / pixel pa; every tap outside the N x N corner gets pi.
  task automatic set_inputs(input int n, input int w, input int sum, input int pa, input int pi);
    int ne;
    logic [7:0] w8, pa8, pi8;
    logic [NW-1:0] n_sz;
    ne  = (n == 0) ? 1 : n;
    w8  = w[7:0];
    pa8 = pa[7:0];
    pi8 = pi[7:0];
    n_sz = n[NW-1:0];
    for (int x = 0; x < MK; x++) begin
      for (int y = 0; y < MK; y++) begin
        kernel[x][y] = ((x < ne) && (y < ne)) ? w8 : pi8;
        window[x][y] = ((x < ne) && (y < ne)) ? pa8 : pi8;
      end
    end
    kernel_size = n_sz;
    kernel_sum  = sum;
  endtask

  task automatic load_kernel(input string tag);
    @(negedge clk);
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    chk($sformatf("%s_ready_pending", tag), win_ready, 1'b0);
    @(negedge clk);
    chk($sformatf("%s_ready_loaded", tag), win_ready, 1'b1);
  endtask

  task automatic run_window(input string tag, input int ne, input int exp_pix, input int exp_err);
    int cnt;
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    chk($sformatf("%s_busy", tag), busy, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk($sformatf("%s_latency", tag), cnt, ne * ne + 32);
    chk($sformatf("%s_pixel", tag), pixel_out, exp_pix);
    chk($sformatf("%s_div_err", tag), div_err, exp_err);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("%s_valid_drop", tag), out_valid, 1'b0);
    chk($sformatf("%s_err_clear", tag), div_err, 1'b0);
    chk($sformatf("%s_idle", tag), busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    n_rst       = 1'b0;
    kernel_size = '0;
    kernel      = '0;
    kernel_sum  = '0;
    kernel_load = 1'b0;
    window      = '0;
    win_valid   = 1'b0;
    out_ready   = 1'b0;

    vecs[0] = '{1, 100, 100, 200, 255, 200, 0};
    vecs[1] = '{3,  10,  90,  50, 255,  50, 0};
    vecs[2] = '{3,   1,   1, 255, 255, 255, 0};
    vecs[3] = '{2,   5,   0,  77, 255,   0, 1};
    vecs[4] = '{7,   2,  98, 100, 255, 100, 0};
    vecs[5] = '{0,   3,   4,  10, 255,   7, 0};
    vecs[6] = '{4,   3,  50,  17, 255,  16, 0};
    vecs[7] = '{2,  64,   1,   1, 255, 255, 0};
    vecs[8] = '{2,  51,   4,   5, 255, 255, 0};

    // Reset state
    #12;
    chk("rst_pixel", pixel_out, 8'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_err", div_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", win_ready, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Windows are refused until a kernel has been captured
    set_inputs(1, 1, 1, 9, 0);
    win_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || win_ready !== 1'b0) viol++;
    end
    win_valid = 1'b0;
    chk("no_kernel_refuse", viol, 0);

    for (int i = 0; i < 9; i++) begin
      set_inputs(vecs[i].n, vecs[i].w, vecs[i].sum, vecs[i].pa, vecs[i].pi);
      load_kernel($sformatf("v%0d", i));
      run_window($sformatf("v%0d", i), (vecs[i].n == 0) ? 1 : vecs[i].n,
                 vecs[i].exp_pix, vecs[i].exp_err);
    end

    // Asymmetric weights/pixels: acc = 4*9 + 1*6 = 42, 42/4 = 10
    set_inputs(2, 0, 4, 0, 255);
    kernel[0][1] = 8'd4;
    kernel[1][1] = 8'd1;
    window[0][0] = 8'd50;
    window[0][1] = 8'd9;
    window[1][0] = 8'd200;
    window[1][1] = 8'd6;
    load_kernel("asym");
    run_window("asym", 2, 10, 0);

    // Late kernel_load, input changes after accept, output back-pressure
    set_inputs(3, 10, 90, 50, 255);
    load_kernel("bp");
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    set_inputs(1, 1, 1, 123, 0);
    @(negedge clk);
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    viol = 0;
    begin
      int cnt;
      cnt = 2;
      while (!out_valid && cnt < 400) begin
        if (win_ready !== 1'b0) viol++;
        @(negedge clk);
        cnt++;
      end
      chk("bp_latency", cnt, 41);
    end
    chk("bp_pixel", pixel_out, 8'd50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pixel_out !== 8'd50 || out_valid !== 1'b1 || win_ready !== 1'b0) viol++;
    end
    chk("bp_hold_stable", viol, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle", busy, 1'b0);
    chk("bp_capture_cycle_ready", win_ready, 1'b0);
    @(negedge clk);
    chk("bp_ready_after_capture", win_ready, 1'b1);
    run_window("bp_new", 1, 123, 0);

    // Asynchronous reset in the middle of MAC
    set_inputs(7, 2, 98, 100, 255);
    load_kernel("rmac");
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rmac_busy", busy, 1'b0);
    chk("rmac_valid", out_valid, 1'b0);
    chk("rmac_ready", win_ready, 1'b0);
    chk("rmac_pixel", pixel_out, 8'd0);
    chk("rmac_state", dbg_state, 2'd0);
    @(negedge clk);
    n_rst = 1'b1;
    win_valid = 1'b1;
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || win_ready !== 1'b0) viol++;
    end
    win_valid = 1'b0;
    chk("rmac_refuse", viol, 0);
    load_kernel("rmac_reload");
    run_window("rmac_run", 7, 100, 0);

    // Asynchronous reset while a divide-by-zero result waits in OUT
    set_inputs(2, 5, 0, 77, 255);
    load_kernel("rout");
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    begin
      int cnt;
      cnt = 0;
      while (!out_valid && cnt < 400) begin
        @(negedge clk);
        cnt++;
      end
      chk("rout_latency", cnt, 36);
    end
    chk("rout_err_set", div_err, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rout_err", div_err, 1'b0);
    chk("rout_valid", out_valid, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_conv.md
KERNEL_CONV -- requirements
Module: kernel_conv

Parameters
REQ-001 SHALL have parameter MAX_KERNEL, default 7: maximum kernel/window edge length in taps.

Interface
REQ-002 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have: n_rst  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have: kernel_size  input  $clog2(MAX_KERNEL)  active edge length N; 0 treated as 1.
REQ-005 SHALL have: kernel  input  MAX_KERNEL x MAX_KERNEL x 8  Gaussian weights, indexed [x][y].
REQ-006 SHALL have: kernel_sum  input  32  sum of active weights (normalisation divisor).
REQ-007 SHALL have: kernel_load  input  1  one-cycle pulse: kernel, kernel_sum and kernel_size are valid.
REQ-008 SHALL have: window  input  MAX_KERNEL x MAX_KERNEL x 8  pixel neighbourhood, indexed [x][y].
REQ-009 SHALL have: win_valid / win_ready  input / output  1 each  window handshake.
REQ-010 SHALL have: pixel_out  output  8  normalised filtered pixel.
REQ-011 SHALL have: out_valid / out_ready  output / input  1 each  result handshake.
REQ-012 SHALL have: div_err  output  1  high with out_valid when the captured kernel_sum was 0.
REQ-013 SHALL have: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, MAC, DIV, OUT.
REQ-015 kernel_load SHALL set a pending flag; in IDLE with pending set, weights, kernel_sum and N SHALL be captured into internal registers, pending cleared, and kernel_ok set, all in one cycle.
REQ-016 kernel_load arriving outside IDLE SHALL only set pending; capture SHALL occur on the first IDLE cycle, using the input values present then.
REQ-017 win_ready SHALL be high only in IDLE with kernel_ok=1 and pending=0; a capture cycle SHALL have priority over window acceptance.
REQ-018 On win_valid && win_ready the window SHALL be copied to an internal register, acc cleared, tap counters (x,y) zeroed, and the FSM SHALL enter MAC.
REQ-019 MAC SHALL process one tap per cycle, acc += win[x][y]*w[x][y] (8x8 unsigned into 32-bit acc), x incrementing to N-1, then wrapping to 0 with y incremented; MAC SHALL end after the tap (N-1,N-1), lasting exactly N*N cycles.
REQ-020 Taps with x>=N or y>=N SHALL never contribute, regardless of their input values.
REQ-021 DIV SHALL compute acc / kernel_sum (unsigned, truncating) by 32-cycle restoring division, one quotient bit per cycle, MSB first.
REQ-022 After DIV, pixel_out SHALL be the quotient saturated to 255, and the FSM SHALL enter OUT.
REQ-023 If kernel_sum==0, DIV SHALL still take 32 cycles, then pixel_out=0 and div_err=1.
REQ-024 out_valid SHALL be high exactly in OUT, N*N+32 cycles after the accepting edge; pixel_out and div_err SHALL be held stable until out_ready.
REQ-025 On out_valid && out_ready the FSM SHALL return to IDLE; div_err SHALL be cleared on the same edge.
REQ-026 Changes to the inputs kernel, window or kernel_size after capture SHALL NOT affect an in-flight result.

Reset
REQ-027 On n_rst low, immediately and regardless of clk: state=IDLE, acc=0, counters=0, pending=0, kernel_ok=0, weight/sum/N registers=0, pixel_out=0, out_valid=0, div_err=0, busy=0, win_ready=0.
REQ-028 Reset asserted mid-MAC/DIV/OUT SHALL discard the in-flight result; after release, win_ready SHALL stay low until a new kernel_load is captured.

Verification
REQ-029 N=1, w[0][0]=100, sum=100, win[0][0]=200 -> out_valid 33 cycles after accept, pixel_out=200, div_err=0.
REQ-030 N=3, all weights 10, sum=90, all pixels 50, non-active taps 255 -> out_valid after 41 cycles, pixel_out=50.
REQ-031 N=3, all weights 1, sum=1, all pixels 255 -> pixel_out=255 (saturated from 2295).
REQ-032 sum=0, any window -> after N*N+32 cycles pixel_out=0, div_err=1.
REQ-033 out_ready held low 5 cycles, with kernel_load pulsed during MAC -> pixel_out stable, win_ready=0 throughout; capture occurs on the first IDLE cycle, then win_ready=1 on the next cycle.
REQ-034 n_rst pulsed low mid-MAC -> all outputs 0 asynchronously; win_valid ignored until kernel_load.
